// File: rtl/ret_stack_pkg.sv
// rtl/ret_stack_pkg.sv - shared stack helpers: tag bit position and modulo-DEPTH pointer wrap
package ret_stack_pkg;

    localparam int RSTK_NBITS = 9;

    // The interrupt tag sits directly above the address bits of each entry.
    function automatic int rstk_tag(input int nbits);
        return nbits;
    endfunction

    function automatic int ptr_wrap_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

    function automatic int ptr_wrap_dec(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/ret_stack_if.sv
// rtl/ret_stack_if.sv - prefetch/PC-mux side bundle of the return-address stack
interface ret_stack_if #(
    parameter int NBITS = 9,
    parameter int DEPTH = 8
);
    localparam int NLVL = $clog2(DEPTH + 1);

    logic             push;
    logic             pop;
    logic             push_itr;
    logic [NBITS-1:0] in;
    logic [NBITS-1:0] out;
    logic             out_itr;
    logic [NLVL-1:0]  level;
    logic             empty;
    logic             full;
    logic [NLVL-1:0]  itr_lvl;
    logic             ovf;
    logic             udf;

    modport master (
        output push, pop, push_itr, in,
        input  out, out_itr, level, empty, full, itr_lvl, ovf, udf
    );

    modport slave (
        input  push, pop, push_itr, in,
        output out, out_itr, level, empty, full, itr_lvl, ovf, udf
    );

endinterface

// File: rtl/ret_stack_ptr.sv
// rtl/ret_stack_ptr.sv - stack pointer, registered pointer-1, level counter and full/empty decode
module ret_stack_ptr
    import ret_stack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NADDR = $clog2(DEPTH),
    parameter int NLVL  = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             adv_i,
    input  logic             ret_i,
    output logic [NADDR-1:0] ptr_o,
    output logic [NADDR-1:0] ptrm1_o,
    output logic [NLVL-1:0]  level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [NADDR-1:0] ptr_q, ptr_d;
    logic [NADDR-1:0] ptrm1_q, ptrm1_d;
    logic [NLVL-1:0]  level_q, level_d;

    assign full_o  = (level_q == NLVL'(DEPTH));
    assign empty_o = (level_q == '0);

    // ptrm1 is kept as its own register so the top-of-stack read never waits on a wrap compare.
    always_comb begin
        ptr_d   = ptr_q;
        ptrm1_d = ptrm1_q;
        level_d = level_q;
        if (adv_i) begin
            ptr_d   = NADDR'(ptr_wrap_inc(int'(ptr_q), DEPTH));
            ptrm1_d = ptr_q;
            if (!full_o) begin
                level_d = level_q + NLVL'(1);
            end
        end else if (ret_i) begin
            ptr_d   = ptrm1_q;
            ptrm1_d = NADDR'(ptr_wrap_dec(int'(ptrm1_q), DEPTH));
            level_d = level_q - NLVL'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            ptrm1_q <= NADDR'(DEPTH - 1);
            level_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            ptrm1_q <= ptrm1_d;
            level_q <= level_d;
        end
    end

    assign ptr_o   = ptr_q;
    assign ptrm1_o = ptrm1_q;
    assign level_o = level_q;

endmodule

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address stack with interrupt tags and sticky ovf/udf
// Build option RET_STACK_GUARD_EN: drop pushes while full instead of overwriting the oldest entry.
module ret_stack
    import ret_stack_pkg::*;
#(
    parameter int NBITS = RSTK_NBITS,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    ret_stack_if.slave  bus
);

    localparam int NADDR = $clog2(DEPTH);
    localparam int NLVL  = $clog2(DEPTH + 1);
    localparam int TAG   = rstk_tag(NBITS);

    logic [NBITS:0]   mem_q [DEPTH];
    logic [NADDR-1:0] ptr, ptrm1, waddr;
    logic [NLVL-1:0]  level;
    logic             full, empty;
    logic             wr_en, adv, ret, replace;
    logic [NBITS:0]   top_ent;
    logic             old_tag;
    logic [NLVL-1:0]  itr_q, itr_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    ret_stack_ptr #(.DEPTH(DEPTH), .NADDR(NADDR), .NLVL(NLVL)) u_ptr (
        .clk_i   (clk),
        .rst_i   (rst),
        .adv_i   (adv),
        .ret_i   (ret),
        .ptr_o   (ptr),
        .ptrm1_o (ptrm1),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign top_ent = mem_q[ptrm1];
    assign old_tag = mem_q[ptr][TAG];

    always_comb begin
        wr_en   = 1'b0;
        adv     = 1'b0;
        ret     = 1'b0;
        replace = 1'b0;
        waddr   = ptr;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        itr_d   = itr_q;
        if (bus.push && bus.pop && !empty) begin
            replace = 1'b1;
            wr_en   = 1'b1;
            waddr   = ptrm1;
        end else if (bus.push) begin
            if (!full) begin
                wr_en = 1'b1;
                adv   = 1'b1;
            end else begin
                ovf_d = 1'b1;
`ifndef RET_STACK_GUARD_EN
                wr_en = 1'b1;
                adv   = 1'b1;
`endif
            end
        end else if (bus.pop) begin
            if (empty) begin
                udf_d = 1'b1;
            end else begin
                ret = 1'b1;
            end
        end
        if (wr_en) begin
            itr_d = itr_d + NLVL'(bus.push_itr);
        end
        if (replace || ret) begin
            itr_d = itr_d - NLVL'(top_ent[TAG]);
        end
        // A circular push while full evicts the oldest frame, which sits at ptr.
        if (adv && full) begin
            itr_d = itr_d - NLVL'(old_tag);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            itr_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            itr_q <= itr_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[waddr] <= {bus.push_itr, bus.in};
        end
    end

    assign bus.out     = empty ? '0 : top_ent[NBITS-1:0];
    assign bus.out_itr = !empty && top_ent[TAG];
    assign bus.level   = level;
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.itr_lvl = itr_q;
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;

endmodule

// File: tb/tb_ret_stack.sv
// tb/tb_ret_stack.sv - directed vector table plus randomized run against a queue model
module tb_ret_stack;

    localparam int NBITS = 9;
    localparam int DEPTH = 5;
    localparam int NLVL  = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ret_stack_if #(.NBITS(NBITS), .DEPTH(DEPTH)) bus ();

    ret_stack #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic             r, p, o, t;
        logic [NBITS-1:0] d;
        logic [NBITS-1:0] eo;
        logic             et;
        int               el, ei;
        logic             eov, eud;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [NBITS:0] mq[$];
    logic           m_ovf, m_udf;

    task automatic add(input logic r, p, o, t, input logic [NBITS-1:0] d,
                       input logic [NBITS-1:0] eo, input logic et, input int el, ei,
                       input logic eov, eud);
        vec_t v;
        v.r = r; v.p = p; v.o = o; v.t = t; v.d = d;
        v.eo = eo; v.et = et; v.el = el; v.ei = ei; v.eov = eov; v.eud = eud;
        vecs.push_back(v);
    endtask

    task automatic mdl(input logic r, p, o, t, input logic [NBITS-1:0] d);
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (p && o && mq.size() > 0) begin
            mq[mq.size()-1] = {t, d};
        end else if (p) begin
            if (mq.size() < DEPTH) begin
                mq.push_back({t, d});
            end else begin
                m_ovf = 1'b1;
`ifndef RET_STACK_GUARD_EN
                void'(mq.pop_front());
                mq.push_back({t, d});
`endif
            end
        end else if (o) begin
            if (mq.size() == 0) m_udf = 1'b1;
            else void'(mq.pop_back());
        end
    endtask

    task automatic drive(input logic r, p, o, t, input logic [NBITS-1:0] d);
        rst = r; bus.push = p; bus.pop = o; bus.push_itr = t; bus.in = d;
        @(posedge clk);
        mdl(r, p, o, t, d);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NBITS-1:0] eo, input logic et,
                           input int el, ei, input logic eov, eud);
        chk({tag, ".out"},     32'(bus.out),     32'(eo));
        chk({tag, ".out_itr"}, 32'(bus.out_itr), 32'(et));
        chk({tag, ".level"},   32'(bus.level),   32'(el));
        chk({tag, ".empty"},   32'(bus.empty),   32'(el == 0));
        chk({tag, ".full"},    32'(bus.full),    32'(el == DEPTH));
        chk({tag, ".itr_lvl"}, 32'(bus.itr_lvl), 32'(ei));
        chk({tag, ".ovf"},     32'(bus.ovf),     32'(eov));
        chk({tag, ".udf"},     32'(bus.udf),     32'(eud));
    endtask

    initial begin
        logic [NBITS-1:0] eo;
        logic             et;
        int               ei;
        logic             r, p, o, t;
        logic [NBITS-1:0] d;
        bit               phase;

        rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.push_itr = 1'b0; bus.in = '0;

        //  r  p  o  t  din     out    tag lvl itr ovf udf
        add(1, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 9'h010, 9'h010, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 9'h020, 9'h020, 0, 2, 0, 0, 0);
        add(0, 1, 0, 0, 9'h030, 9'h030, 0, 3, 0, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h020, 0, 2, 0, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h010, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h000, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 9'h044, 9'h044, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 9'h100, 9'h100, 1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 9'h055, 9'h055, 0, 2, 1, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h100, 1, 1, 1, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 9'h011, 9'h011, 0, 1, 0, 0, 0);
        add(0, 1, 0, 0, 9'h022, 9'h022, 0, 2, 0, 0, 0);
        add(0, 1, 1, 0, 9'h077, 9'h077, 0, 2, 0, 0, 0);
        add(0, 0, 1, 0, 9'h000, 9'h011, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 9'h000, 9'h000, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            add(0, 1, 0, 0, NBITS'(k), NBITS'(k), 0, k, 0, 0, 0);
        end
`ifdef RET_STACK_GUARD_EN
        add(0, 1, 0, 0, 9'h006, 9'h005, 0, 5, 0, 1, 0);
        for (int k = 4; k >= 0; k--) begin
            add(0, 0, 1, 0, 9'h000, NBITS'(k), 0, k, 0, 1, 0);
        end
`else
        add(0, 1, 0, 0, 9'h006, 9'h006, 0, 5, 0, 1, 0);
        for (int k = 4; k >= 1; k--) begin
            add(0, 0, 1, 0, 9'h000, NBITS'(k + 1), 0, k, 0, 1, 0);
        end
        add(0, 0, 1, 0, 9'h000, 9'h000, 0, 0, 0, 1, 0);
`endif
        add(0, 1, 0, 0, 9'h007, 9'h007, 0, 1, 0, 1, 0);
        add(0, 1, 0, 0, 9'h008, 9'h008, 0, 2, 0, 1, 0);
        add(0, 1, 0, 0, 9'h009, 9'h009, 0, 3, 0, 1, 0);
        add(1, 1, 0, 0, 9'h0aa, 9'h000, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 9'h033, 9'h033, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 9'h000, 9'h000, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].p, vecs[i].o, vecs[i].t, vecs[i].d);
            chk_all($sformatf("vec%0d", i), vecs[i].eo, vecs[i].et, vecs[i].el,
                    vecs[i].ei, vecs[i].eov, vecs[i].eud);
        end

        phase = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 40 == 0) phase = ~phase;
            r = ($urandom_range(0, 79) == 0);
            p = ($urandom_range(0, 99) < (phase ? 75 : 30));
            o = ($urandom_range(0, 99) < (phase ? 30 : 70));
            t = $urandom_range(0, 1);
            d = NBITS'($urandom);
            drive(r, p, o, t, d);
            eo = (mq.size() > 0) ? mq[mq.size()-1][NBITS-1:0] : '0;
            et = (mq.size() > 0) ? mq[mq.size()-1][NBITS] : 1'b0;
            ei = 0;
            foreach (mq[j]) ei += int'(mq[j][NBITS]);
            chk_all($sformatf("rnd%0d", n), eo, et, mq.size(), ei, m_ovf, m_udf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
